// File: rtl/exec_pkg.sv
// -----------------------------------------------------------------------------
// exec_pkg
// Shared types for the execute stage: ALU-op and branch-class encodings (3 bits
// each, matching the decode register) and the execute FSM state type.
// -----------------------------------------------------------------------------
package exec_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_XOR = 3'd3,
      OP_SLL = 3'd4,
      OP_SRL = 3'd5,
      OP_ROL = 3'd6,
      OP_MUL = 3'd7
   } alu_op_e;

   // Encoding 3'd7 is unused and behaves as BR_NONE.
   typedef enum logic [2:0] {
      BR_NONE = 3'd0,
      BR_EQZ  = 3'd1,
      BR_NEZ  = 3'd2,
      BR_LTZ  = 3'd3,
      BR_GEZ  = 3'd4,
      BR_JMP  = 3'd5,
      BR_JR   = 3'd6
   } br_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

endpackage

// File: rtl/exec_mul_iter.sv
// -----------------------------------------------------------------------------
// exec_mul_iter
// Iterative shift-add multiplier returning the low WIDTH bits of the unsigned
// product. MUL_K multiplier bits are retired per cycle, so a product takes
// WIDTH/MUL_K steps; the first step is folded into the start cycle so the
// product is complete (o_done) WIDTH/MUL_K-1 cycles after i_start.
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   i_start      load operands and perform the first step
//   i_abort      drop the operation in progress (priority over i_start)
//   i_a, i_b     multiplicand / multiplier
//   o_busy       an operation is in progress or its product is being presented
//   o_done       o_product holds the finished product this cycle
//   o_product    running / final product
// -----------------------------------------------------------------------------
module exec_mul_iter #(
   parameter int WIDTH = 16,
   parameter int MUL_K = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_start,
   input  logic             i_abort,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_product
);

   localparam int STEPS = WIDTH / MUL_K;
   localparam int CNT_W = $clog2(STEPS + 1);

   logic [WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0] r_mplier;
   logic [WIDTH-1:0] r_acc;
   logic [CNT_W-1:0] r_cnt;
   logic             r_busy;

   // Sum of the multiplicand shifted by each set bit of one MUL_K-bit digit.
   function automatic logic [WIDTH-1:0] partial(input logic [WIDTH-1:0] mcand,
                                                input logic [MUL_K-1:0] bits);
      logic [WIDTH-1:0] sum;
      sum = '0;
      for (int k = 0; k < MUL_K; k++) begin
         if (bits[k]) sum = sum + (mcand << k);
      end
      return sum;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_busy   <= 1'b0;
      end else if (i_abort) begin
         r_busy <= 1'b0;
         r_cnt  <= '0;
      end else if (i_start) begin
         r_acc    <= partial(i_a, i_b[MUL_K-1:0]);
         r_mcand  <= i_a << MUL_K;
         r_mplier <= i_b >> MUL_K;
         r_cnt    <= CNT_W'(STEPS - 1);
         r_busy   <= 1'b1;
      end else if (r_busy) begin
         if (r_cnt != '0) begin
            r_acc    <= r_acc + partial(r_mcand, r_mplier[MUL_K-1:0]);
            r_mcand  <= r_mcand << MUL_K;
            r_mplier <= r_mplier >> MUL_K;
            r_cnt    <= r_cnt - 1'b1;
         end else begin
            // Product has been presented for one cycle; the caller took it.
            r_busy <= 1'b0;
         end
      end
   end

   assign o_busy    = r_busy;
   assign o_done    = r_busy && (r_cnt == '0);
   assign o_product = r_acc;

endmodule

// File: rtl/exec_stage_mc.sv
// -----------------------------------------------------------------------------
// exec_stage_mc
// Pipelined execute stage: ALU, branch/jump resolution and an optional
// iterative multiplier, with a registered EX/MEM output and valid/ready
// handshakes on both sides. Multi-cycle work and back-pressure stall upstream
// through in_ready.
//
// Configuration macro: EXEC_STAGE_MUL_EN
//   defined   - MUL runs on exec_mul_iter, WIDTH/MUL_K cycles in BUSY.
//   undefined - no multiplier; MUL completes in one cycle with result 0 and
//               out_illegal set.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid / in_ready             upstream handshake
//   in_op, in_br                    ALU op (alu_op_e), branch class (br_e)
//   in_a, in_b, in_imm, in_npc      operands, immediate, PC+2
//   in_use_imm, in_link             B := imm; result := npc (JAL/JALR)
//   in_rd                           destination register, passed through
//   flush                           discard in-flight and pending work
//   out_valid / out_ready           downstream handshake
//   out_result, out_rd              result and destination register
//   out_redirect, out_target        branch taken / jump and its target
//   out_z, out_n, out_illegal       result zero / negative, unsupported op
// -----------------------------------------------------------------------------
module exec_stage_mc
   import exec_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int RADDR_W = 3,
   parameter int MUL_K   = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [2:0]         in_op,
   input  logic [2:0]         in_br,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   input  logic [WIDTH-1:0]   in_imm,
   input  logic [WIDTH-1:0]   in_npc,
   input  logic               in_use_imm,
   input  logic               in_link,
   input  logic [RADDR_W-1:0] in_rd,
   input  logic               flush,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_result,
   output logic [RADDR_W-1:0] out_rd,
   output logic               out_redirect,
   output logic [WIDTH-1:0]   out_target,
   output logic               out_z,
   output logic               out_n,
   output logic               out_illegal
);

   localparam int SH_W  = $clog2(WIDTH);
   localparam int STEPS = WIDTH / MUL_K;
   localparam int CNT_W = $clog2(STEPS + 1);

   state_e             r_state, w_state_nxt;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;

   logic               r_valid, r_redirect, r_z, r_n, r_illegal;
   logic [WIDTH-1:0]   r_result, r_target;
   logic [RADDR_W-1:0] r_rd;

   // Side information of a MUL held while the multiplier iterates.
   logic [RADDR_W-1:0] r_pend_rd;
   logic               r_pend_redir, r_pend_link;
   logic [WIDTH-1:0]   r_pend_target, r_pend_npc;

   alu_op_e            w_op;
   br_e                w_br;
   logic [WIDTH-1:0]   w_opb, w_target, w_prod;
   logic               w_taken, w_illegal, w_acc, w_mul_start, w_mul_busy, w_fin;
   logic               w_load;
   logic [WIDTH-1:0]   w_ld_result, w_ld_target;
   logic [RADDR_W-1:0] w_ld_rd;
   logic               w_ld_redir, w_ld_illegal;

   function automatic logic [WIDTH-1:0] alu(input alu_op_e op,
                                            input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
      logic [SH_W-1:0]    sh;
      logic [2*WIDTH-1:0] rot;
      logic [WIDTH-1:0]   res;
      sh  = b[SH_W-1:0];
      // Rotate left: the upper half of {a,a} shifted left by sh.
      rot = {a, a} << sh;
      case (op)
         OP_ADD:  res = a + b;
         OP_SUB:  res = b - a;   // ISA defines SUB as B - A
         OP_AND:  res = a & b;
         OP_XOR:  res = a ^ b;
         OP_SLL:  res = a << sh;
         OP_SRL:  res = a >> sh;
         OP_ROL:  res = rot[2*WIDTH-1:WIDTH];
         default: res = '0;      // MUL result comes from the multiplier
      endcase
      return res;
   endfunction

   function automatic logic br_taken(input br_e br, input logic signed [WIDTH-1:0] a);
      logic t;
      case (br)
         BR_EQZ:         t = (a == '0);
         BR_NEZ:         t = (a != '0);
         BR_LTZ:         t = (a < 0);
         BR_GEZ:         t = (a >= 0);
         BR_JMP, BR_JR:  t = 1'b1;
         default:        t = 1'b0;
      endcase
      return t;
   endfunction

   assign w_op     = alu_op_e'(in_op);
   assign w_br     = br_e'(in_br);
   assign w_opb    = in_use_imm ? in_imm : in_b;
   assign w_taken  = br_taken(w_br, in_a);
   assign w_target = ((w_br == BR_JR) ? in_a : in_npc) + in_imm;

   assign in_ready = (r_state == ST_IDLE) && !w_mul_busy && (!r_valid || out_ready) && !flush;
   assign w_acc    = in_valid && in_ready;

`ifdef EXEC_STAGE_MUL_EN
   logic w_mul_done;

   assign w_mul_start = w_acc && (w_op == OP_MUL);
   assign w_illegal   = 1'b0;
   // Counter and multiplier run in lock-step; both must agree on completion.
   assign w_fin       = (r_state == ST_BUSY) && (r_cnt == CNT_W'(1)) && w_mul_done;

   exec_mul_iter #(
      .WIDTH (WIDTH),
      .MUL_K (MUL_K)
   ) u_mul (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_start   (w_mul_start),
      .i_abort   (flush),
      .i_a       (in_a),
      .i_b       (w_opb),
      .o_busy    (w_mul_busy),
      .o_done    (w_mul_done),
      .o_product (w_prod)
   );
`else
   assign w_mul_start = 1'b0;
   assign w_illegal   = (w_op == OP_MUL);
   assign w_fin       = 1'b0;
   assign w_mul_busy  = 1'b0;
   assign w_prod      = '0;
`endif

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // FSM next state
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_IDLE: begin
            if (w_mul_start) begin
               w_state_nxt = ST_BUSY;
               w_cnt_nxt   = CNT_W'(STEPS);
            end
         end
         ST_BUSY: begin
            if (r_cnt != '0) w_cnt_nxt = r_cnt - 1'b1;
            if (w_fin)       w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      if (flush) begin
         w_state_nxt = ST_IDLE;
         w_cnt_nxt   = '0;
      end
   end

   // Output-register load source: a finishing MUL or a freshly accepted op.
   assign w_load = (w_acc && !w_mul_start) || w_fin;

   always_comb begin
      w_ld_result  = '0;
      w_ld_rd      = '0;
      w_ld_redir   = 1'b0;
      w_ld_target  = '0;
      w_ld_illegal = 1'b0;
      if (r_state == ST_BUSY) begin
         w_ld_result = r_pend_link ? r_pend_npc : w_prod;
         w_ld_rd     = r_pend_rd;
         w_ld_redir  = r_pend_redir;
         w_ld_target = r_pend_target;
      end else begin
         w_ld_result  = in_link ? in_npc : alu(w_op, in_a, w_opb);
         w_ld_rd      = in_rd;
         w_ld_redir   = w_taken;
         w_ld_target  = w_target;
         w_ld_illegal = w_illegal;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend_rd     <= '0;
         r_pend_redir  <= 1'b0;
         r_pend_link   <= 1'b0;
         r_pend_target <= '0;
         r_pend_npc    <= '0;
      end else if (w_mul_start) begin
         r_pend_rd     <= in_rd;
         r_pend_redir  <= w_taken;
         r_pend_link   <= in_link;
         r_pend_target <= w_target;
         r_pend_npc    <= in_npc;
      end
   end

   // EX/MEM output register; flush wins over any load on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid    <= 1'b0;
         r_redirect <= 1'b0;
         r_illegal  <= 1'b0;
         r_result   <= '0;
         r_target   <= '0;
         r_rd       <= '0;
         r_z        <= 1'b0;
         r_n        <= 1'b0;
      end else if (flush) begin
         r_valid    <= 1'b0;
         r_redirect <= 1'b0;
      end else if (w_load) begin
         r_valid    <= 1'b1;
         r_redirect <= w_ld_redir;
         r_illegal  <= w_ld_illegal;
         r_result   <= w_ld_result;
         r_target   <= w_ld_target;
         r_rd       <= w_ld_rd;
         r_z        <= (w_ld_result == '0);
         r_n        <= w_ld_result[WIDTH-1];
      end else if (out_ready) begin
         // Redirect is tied to the valid result so it never outlives it.
         r_valid    <= 1'b0;
         r_redirect <= 1'b0;
      end
   end

   assign out_valid    = r_valid;
   assign out_result   = r_result;
   assign out_rd       = r_rd;
   assign out_redirect = r_redirect;
   assign out_target   = r_target;
   assign out_z        = r_z;
   assign out_n        = r_n;
   assign out_illegal  = r_illegal;

endmodule

// File: tb/tb_exec_stage_mc.sv
module tb_exec_stage_mc;
   import exec_pkg::*;

`ifdef EXEC_STAGE_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready;
   logic [2:0]  in_op, in_br;
   logic [15:0] in_a, in_b, in_imm, in_npc;
   logic        in_use_imm, in_link;
   logic [2:0]  in_rd;
   logic        flush;
   logic        out_valid, out_ready;
   logic [15:0] out_result, out_target;
   logic [2:0]  out_rd;
   logic        out_redirect, out_z, out_n, out_illegal;

   always #5 clk = ~clk;

   exec_stage_mc #(.WIDTH(16), .RADDR_W(3), .MUL_K(1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_br(in_br), .in_a(in_a), .in_b(in_b), .in_imm(in_imm),
      .in_npc(in_npc), .in_use_imm(in_use_imm), .in_link(in_link), .in_rd(in_rd),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_rd(out_rd), .out_redirect(out_redirect),
      .out_target(out_target), .out_z(out_z), .out_n(out_n), .out_illegal(out_illegal)
   );

   typedef struct {
      logic [15:0] result;
      logic [2:0]  rd;
      logic        redir;
      logic [15:0] target;
      logic        z, n, ill;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference model of one operation.
   function automatic exp_t model(input logic [2:0] op, input logic [2:0] br,
                                  input logic [15:0] a, input logic [15:0] b,
                                  input logic [15:0] imm, input logic [15:0] npc,
                                  input logic use_imm, input logic link, input logic [2:0] rd);
      exp_t e;
      logic [15:0] bb, r;
      logic [31:0] full;
      int sh;
      logic tk;
      bb = use_imm ? imm : b;
      sh = int'(bb[3:0]);
      full = 32'(a) * 32'(bb);
      case (op)
         3'd0: r = a + bb;
         3'd1: r = bb - a;
         3'd2: r = a & bb;
         3'd3: r = a ^ bb;
         3'd4: r = a << sh;
         3'd5: r = a >> sh;
         3'd6: begin
            r = a;
            for (int i = 0; i < sh; i++) r = {r[14:0], r[15]};
         end
         default: r = MUL_EN ? full[15:0] : 16'h0000;
      endcase
      if (link) r = npc;
      case (br)
         3'd1: tk = (a == 16'h0);
         3'd2: tk = (a != 16'h0);
         3'd3: tk = a[15];
         3'd4: tk = !a[15];
         3'd5, 3'd6: tk = 1'b1;
         default: tk = 1'b0;
      endcase
      e.result = r;
      e.rd     = rd;
      e.redir  = tk;
      e.target = (br == 3'd6) ? (a + imm) : (npc + imm);
      e.z      = (r == 16'h0);
      e.n      = r[15];
      e.ill    = (op == 3'd7) && !MUL_EN;
      return e;
   endfunction

   // Scoreboard: compare each result as it is handed downstream.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         check("sb_has_entry", 32'(q.size() != 0), 32'd1);
         if (q.size() != 0) begin
            mon_e = q.pop_front();
            check("sb_result",   32'(out_result),   32'(mon_e.result));
            check("sb_rd",       32'(out_rd),       32'(mon_e.rd));
            check("sb_redirect", 32'(out_redirect), 32'(mon_e.redir));
            if (mon_e.redir) check("sb_target", 32'(out_target), 32'(mon_e.target));
            check("sb_z",        32'(out_z),        32'(mon_e.z));
            check("sb_n",        32'(out_n),        32'(mon_e.n));
            check("sb_illegal",  32'(out_illegal),  32'(mon_e.ill));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   // Present an op and wait (bounded) until it is accepted; leaves in_valid high.
   task automatic drive(input logic [2:0] op, input logic [2:0] br,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] imm, input logic [15:0] npc,
                        input logic use_imm, input logic link, input logic [2:0] rd,
                        output int waits);
      in_op = op; in_br = br; in_a = a; in_b = b; in_imm = imm; in_npc = npc;
      in_use_imm = use_imm; in_link = link; in_rd = rd; in_valid = 1'b1;
      waits = 0;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         waits++;
         if (waits > 100) break;
      end
      if (waits > 100) begin
         check("accept_timeout", 32'(waits), 32'd0);
         in_valid = 1'b0;
      end else begin
         @(posedge clk);
         q.push_back(model(op, br, a, b, imm, npc, use_imm, link, rd));
         #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w, busy, seen;
      rst_n = 1'b0; in_valid = 1'b0; in_op = 3'd0; in_br = 3'd0; in_a = '0; in_b = '0;
      in_imm = '0; in_npc = '0; in_use_imm = 1'b0; in_link = 1'b0; in_rd = '0;
      flush = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("rst_valid",    32'(out_valid),    32'd0);
      check("rst_result",   32'(out_result),   32'd0);
      check("rst_redirect", 32'(out_redirect), 32'd0);
      check("rst_z",        32'(out_z),        32'd0);
      check("rst_illegal",  32'(out_illegal),  32'd0);
      check("rst_in_ready", 32'(in_ready),     32'd1);
      step();

      // ADD overflow into the sign bit
      drive(OP_ADD, BR_NONE, 16'h7FFF, 16'h0001, 16'h0, 16'h0, 1'b0, 1'b0, 3'd1, w);
      idle();
      @(negedge clk);
      check("add_valid_next", 32'(out_valid), 32'd1);
      check("add_result",     32'(out_result), 32'h8000);
      check("add_n",          32'(out_n), 32'd1);
      check("add_z",          32'(out_z), 32'd0);
      step();

      // Back-to-back ops: every one must be accepted with no wait
      drive(OP_SUB, BR_NONE, 16'd3,    16'd10,   16'h0,   16'h0, 1'b0, 1'b0, 3'd2, w);
      drive(OP_XOR, BR_NONE, 16'hFF00, 16'h0FF0, 16'h0,   16'h0, 1'b0, 1'b0, 3'd3, w);
      check("b2b_xor_wait", 32'(w), 32'd0);
      drive(OP_AND, BR_NONE, 16'hF0F0, 16'hFF00, 16'h0,   16'h0, 1'b0, 1'b0, 3'd4, w);
      check("b2b_and_wait", 32'(w), 32'd0);
      drive(OP_SLL, BR_NONE, 16'h0003, 16'hFFFF, 16'h0004, 16'h0, 1'b1, 1'b0, 3'd5, w);
      check("b2b_sll_wait", 32'(w), 32'd0);
      drive(OP_SRL, BR_NONE, 16'h8000, 16'd15,   16'h0,   16'h0, 1'b0, 1'b0, 3'd6, w);
      drive(OP_ROL, BR_NONE, 16'h8001, 16'h0014, 16'h0,   16'h0, 1'b0, 1'b0, 3'd7, w);
      drive(OP_SUB, BR_NONE, 16'd5,    16'd5,    16'h0,   16'h0, 1'b0, 1'b0, 3'd1, w);
      check("b2b_sub0_wait", 32'(w), 32'd0);
      idle();
      step(); step();

      // MUL 0x0123 * 0x0045
      drive(OP_MUL, BR_NONE, 16'h0123, 16'h0045, 16'h0, 16'h0, 1'b0, 1'b0, 3'd2, w);
      idle();
`ifdef EXEC_STAGE_MUL_EN
      busy = 0; seen = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (out_valid) begin seen = 1; break; end
         if (!in_ready) busy++;
      end
      check("mul_valid_seen",  32'(seen), 32'd1);
      check("mul_busy_cycles", 32'(busy), 32'd16);
      check("mul_result",      32'(out_result), 32'h4E6F);
`else
      @(negedge clk);
      check("mul_valid_next", 32'(out_valid),   32'd1);
      check("mul_illegal",    32'(out_illegal), 32'd1);
      check("mul_result",     32'(out_result),  32'h0000);
`endif
      step();

      // Branches: npc=0x0010, imm=0xFFF8
      drive(OP_ADD, BR_EQZ, 16'h0000, 16'h0, 16'hFFF8, 16'h0010, 1'b0, 1'b0, 3'd1, w);
      drive(OP_ADD, BR_EQZ, 16'h0001, 16'h0, 16'hFFF8, 16'h0010, 1'b0, 1'b0, 3'd2, w);
      drive(OP_ADD, BR_NEZ, 16'h0001, 16'h0, 16'hFFF8, 16'h0010, 1'b0, 1'b0, 3'd3, w);
      drive(OP_ADD, BR_LTZ, 16'h8000, 16'h0, 16'hFFF8, 16'h0010, 1'b0, 1'b0, 3'd4, w);
      drive(OP_ADD, BR_GEZ, 16'h8000, 16'h0, 16'hFFF8, 16'h0010, 1'b0, 1'b0, 3'd5, w);
      drive(OP_ADD, BR_JR,  16'h0100, 16'h0, 16'hFFF8, 16'h0010, 1'b0, 1'b0, 3'd6, w);
      drive(OP_ADD, BR_JMP, 16'h1234, 16'h0, 16'hFFF8, 16'h0010, 1'b0, 1'b1, 3'd7, w);
      idle();
      @(negedge clk);
      check("jal_result",   32'(out_result),   32'h0010);
      check("jal_redirect", 32'(out_redirect), 32'd1);
      check("jal_target",   32'(out_target),   32'h0008);
      step(); step();

      // Back-pressure: hold for 3 cycles, then release
      drive(OP_ADD, BR_NONE, 16'd2, 16'd3, 16'h0, 16'h0, 1'b0, 1'b0, 3'd5, w);
      out_ready = 1'b0;
      idle();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_valid_hold",  32'(out_valid),  32'd1);
         check("bp_result_hold", 32'(out_result), 32'd5);
         check("bp_rd_hold",     32'(out_rd),     32'd5);
         check("bp_in_ready",    32'(in_ready),   32'd0);
         step();
      end
      out_ready = 1'b1;
      drive(OP_XOR, BR_NONE, 16'h00FF, 16'h0F0F, 16'h0, 16'h0, 1'b0, 1'b0, 3'd6, w);
      check("bp_release_wait", 32'(w), 32'd0);
      idle();
      step();

      // Flush a pending jump result held by back-pressure
      drive(OP_ADD, BR_JMP, 16'd1, 16'd1, 16'h0004, 16'h0020, 1'b0, 1'b0, 3'd3, w);
      out_ready = 1'b0;
      idle();
      @(negedge clk);
      check("fl_pre_valid",    32'(out_valid),    32'd1);
      check("fl_pre_redirect", 32'(out_redirect), 32'd1);
      step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      void'(q.pop_back());
      @(negedge clk);
      check("fl_valid_clr",    32'(out_valid),    32'd0);
      check("fl_redirect_clr", 32'(out_redirect), 32'd0);
      step();
      out_ready = 1'b1;

      // Flush blocks accept even when the stage is otherwise ready
      in_op = OP_ADD; in_br = BR_NONE; in_a = 16'd9; in_b = 16'd9; in_link = 1'b0;
      in_use_imm = 1'b0; in_rd = 3'd1; in_valid = 1'b1; flush = 1'b1;
      @(negedge clk);
      check("fl_blocks_ready", 32'(in_ready), 32'd0);
      step();
      flush = 1'b0; idle();
      @(negedge clk);
      check("fl_no_accept", 32'(out_valid), 32'd0);
      step();

`ifdef EXEC_STAGE_MUL_EN
      // Flush during BUSY cycle 5
      drive(OP_MUL, BR_NONE, 16'h0011, 16'h0022, 16'h0, 16'h0, 1'b0, 1'b0, 3'd4, w);
      idle();
      repeat (4) @(posedge clk);
      #1 flush = 1'b1;
      @(negedge clk);
      check("flbusy_ready_low", 32'(in_ready), 32'd0);
      step();
      flush = 1'b0;
      void'(q.pop_back());
      @(negedge clk);
      check("flbusy_idle", 32'(in_ready), 32'd1);
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_valid) seen = 1;
      end
      check("flbusy_no_valid", 32'(seen), 32'd0);
      step();
      drive(OP_ADD, BR_NONE, 16'd5, 16'd6, 16'h0, 16'h0, 1'b0, 1'b0, 3'd6, w);
      idle();
      step(); step();
      // Reset in the middle of a MUL
      drive(OP_MUL, BR_NONE, 16'd7, 16'd9, 16'h0, 16'h0, 1'b0, 1'b0, 3'd7, w);
      idle();
      step(); step(); step();
      @(negedge clk);
      check("prerst_result", 32'(out_result), 32'd11);
      check("prerst_busy",   32'(in_ready),   32'd0);
`else
      // Reset while a jump result is held
      drive(OP_ADD, BR_JMP, 16'd5, 16'd6, 16'h0002, 16'h0040, 1'b0, 1'b0, 3'd7, w);
      out_ready = 1'b0;
      idle();
      @(negedge clk);
      check("prerst_valid", 32'(out_valid), 32'd1);
`endif
      #1 rst_n = 1'b0;
      #1;
      check("arst_valid",    32'(out_valid),    32'd0);
      check("arst_result",   32'(out_result),   32'd0);
      check("arst_rd",       32'(out_rd),       32'd0);
      check("arst_redirect", 32'(out_redirect), 32'd0);
      check("arst_target",   32'(out_target),   32'd0);
      check("arst_flags",    32'({out_z, out_n, out_illegal}), 32'd0);
      q.delete();
      out_ready = 1'b1;
      step();
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_valid) seen = 1;
      end
      check("postrst_no_valid", 32'(seen), 32'd0);
      check("postrst_ready",    32'(in_ready), 32'd1);
      step();

      check("sb_drain", 32'(q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
